seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns for the seven-segment scan driver.
// Patterns are active-low, segment a on bit 0 through g on bit 6.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_ROM [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment pattern; valid drops for 10-15 in BCD mode.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] seg,
   output logic       valid
);

   assign valid = hex_mode || (nibble <= 4'd9);
   assign seg   = valid ? SEG_ROM[nibble] : SEG_BLANK;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner with frame-synchronous shadow
// registers, per-digit blanking/blinking and registered outputs.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS    = 8,
   parameter int CLK_DIV   = 50000,
   parameter int BLINK_DIV = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] data,
   input  logic                load,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   digit_en,
   input  logic [DIGITS-1:0]   blink_en,
   input  logic                hex_mode,
   output logic [6:0]          seg,
   output logic                dp_n,
   output logic [DIGITS-1:0]   an,
   output logic                frame_done,
   output logic                upd_pend
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

   logic [DW-1:0]       div;
   logic [IW-1:0]       idx;
   logic [BW-1:0]       fcnt;
   logic                phase;
   logic                tick;
   logic                wrap;

   logic [4*DIGITS-1:0] pend_data, disp_data;
   logic [DIGITS-1:0]   pend_dp, disp_dp;
   logic [DIGITS-1:0]   pend_en, disp_en;
   logic [DIGITS-1:0]   pend_blink, disp_blink;

   logic [3:0]          nib;
   logic [6:0]          dec_seg;
   logic                dec_valid;
   logic                blank;

   assign tick = (div == DIV_MAX);
   assign wrap = tick && (idx == IDX_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         idx <= '0;
      end else if (tick) begin
         div <= '0;
         idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end else begin
         div <= div + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt       <= '0;
         phase      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap;
         if (wrap) begin
            if (fcnt == BLK_MAX) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + BW'(1);
            end
         end
      end
   end

   // Display only changes on a frame wrap so a scan never mixes old and new.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_en    <= '0;
         pend_blink <= '0;
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_en    <= '0;
         disp_blink <= '0;
         upd_pend   <= 1'b0;
      end else if (load && wrap) begin
         disp_data  <= data;
         disp_dp    <= dp_in;
         disp_en    <= digit_en;
         disp_blink <= blink_en;
         upd_pend   <= 1'b0;
      end else if (load) begin
         pend_data  <= data;
         pend_dp    <= dp_in;
         pend_en    <= digit_en;
         pend_blink <= blink_en;
         upd_pend   <= 1'b1;
      end else if (wrap && upd_pend) begin
         disp_data  <= pend_data;
         disp_dp    <= pend_dp;
         disp_en    <= pend_en;
         disp_blink <= pend_blink;
         upd_pend   <= 1'b0;
      end
   end

   assign nib = disp_data[4*idx +: 4];

   seg7_decode u_dec (
      .nibble   (nib),
      .hex_mode (hex_mode),
      .seg      (dec_seg),
      .valid    (dec_valid)
   );

   assign blank = !disp_en[idx]
               || (disp_blink[idx] && !phase)
               || !dec_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an   <= '1;
         seg  <= SEG_BLANK;
         dp_n <= 1'b1;
      end else if (blank) begin
         an   <= '1;
         seg  <= SEG_BLANK;
         dp_n <= 1'b1;
      end else begin
         an   <= ~(DIGITS'(1) << idx);
         seg  <= dec_seg;
         dp_n <= ~disp_dp[idx];
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=4, BLINK_DIV=2.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data = '0;
   logic        load = 1'b0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  digit_en = '0;
   logic [3:0]  blink_en = '0;
   logic        hex_mode = 1'b1;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  an;
   logic        frame_done;
   logic        upd_pend;

   int total = 0;
   int bad = 0;
   int k = 0;

   logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [6:0] seg_tab [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .DIGITS    (4),
      .CLK_DIV   (4),
      .BLINK_DIV (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data),
      .load       (load),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .blink_en   (blink_en),
      .hex_mode   (hex_mode),
      .seg        (seg),
      .dp_n       (dp_n),
      .an         (an),
      .frame_done (frame_done),
      .upd_pend   (upd_pend)
   );

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      data     = '0;
      load     = 1'b0;
      dp_in    = '0;
      digit_en = '0;
      blink_en = '0;
      hex_mode = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
   endtask

   task automatic load_vec(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] en, input logic [3:0] bl);
      data     = d;
      dp_in    = dp;
      digit_en = en;
      blink_en = bl;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   task automatic test_reset();
      logic lit;
      do_reset();
      total++;
      if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1
          || upd_pend !== 1'b0 || frame_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_state an=%h seg=%h dp_n=%b upd=%b fd=%b want F 7f 1 0 0",
                  an, seg, dp_n, upd_pend, frame_done);
      end
      load_vec(16'h3210, 4'h0, 4'hF, 4'h0);
      while (k < 22) step();
      load_vec(16'h5555, 4'h0, 4'hF, 4'h0);
      total++;
      if (upd_pend !== 1'b1 || an !== 4'hD) begin
         bad++;
         $display("FAIL pre_reset upd=%b an=%h want 1 D", upd_pend, an);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1
          || upd_pend !== 1'b0 || frame_done !== 1'b0) begin
         bad++;
         $display("FAIL async_reset an=%h seg=%h dp_n=%b upd=%b fd=%b want F 7f 1 0 0",
                  an, seg, dp_n, upd_pend, frame_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      lit = 1'b0;
      while (k < 24) begin
         step();
         if (an !== 4'hF || upd_pend !== 1'b0) lit = 1'b1;
      end
      total++;
      if (lit) begin
         bad++;
         $display("FAIL reset_discard an=%h upd=%b want F 0", an, upd_pend);
      end
   endtask

   task automatic test_scan();
      int d;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      do_reset();
      load_vec(16'h3210, 4'b0100, 4'hF, 4'h0);
      total++;
      if (upd_pend !== 1'b1) begin
         bad++;
         $display("FAIL scan_pend upd=%b want 1", upd_pend);
      end
      while (k < 48) begin
         step();
         d = ((k - 1) / 4) % 4;
         if (k <= 16) begin
            ea = 4'hF; es = 7'h7F; ed = 1'b1;
         end else begin
            ea = an_tab[d]; es = seg_tab[d]; ed = (d == 2) ? 1'b0 : 1'b1;
         end
         total++;
         if (an !== ea || seg !== es || dp_n !== ed) begin
            bad++;
            $display("FAIL scan k=%0d an=%h seg=%h dp_n=%b want %h %h %b",
                     k, an, seg, dp_n, ea, es, ed);
         end
         total++;
         if (frame_done !== (k % 16 == 0) || upd_pend !== (k < 16)) begin
            bad++;
            $display("FAIL scan_flags k=%0d fd=%b upd=%b want %b %b",
                     k, frame_done, upd_pend, (k % 16 == 0), (k < 16));
         end
      end
   endtask

   task automatic test_shadow();
      int d;
      logic [6:0] es;
      do_reset();
      load_vec(16'h3210, 4'h0, 4'hF, 4'h0);
      while (k < 20) step();
      load_vec(16'h9999, 4'h0, 4'hF, 4'h0);
      total++;
      if (upd_pend !== 1'b1) begin
         bad++;
         $display("FAIL shadow_pend upd=%b want 1", upd_pend);
      end
      while (k < 48) begin
         step();
         d = ((k - 1) / 4) % 4;
         es = (k <= 32) ? seg_tab[d] : 7'h10;
         total++;
         if (an !== an_tab[d] || seg !== es || upd_pend !== (k < 32)) begin
            bad++;
            $display("FAIL shadow k=%0d an=%h seg=%h upd=%b want %h %h %b",
                     k, an, seg, upd_pend, an_tab[d], es, (k < 32));
         end
      end
   endtask

   task automatic test_coincident();
      int d;
      logic seen;
      do_reset();
      load_vec(16'h3210, 4'h0, 4'hF, 4'h0);
      while (k < 31) step();
      load_vec(16'h9999, 4'h0, 4'hF, 4'h0);
      total++;
      if (upd_pend !== 1'b0 || an !== 4'h7 || seg !== 7'h30) begin
         bad++;
         $display("FAIL coincident_edge upd=%b an=%h seg=%h want 0 7 30",
                  upd_pend, an, seg);
      end
      seen = 1'b0;
      while (k < 48) begin
         step();
         d = ((k - 1) / 4) % 4;
         if (upd_pend !== 1'b0) seen = 1'b1;
         total++;
         if (an !== an_tab[d] || seg !== 7'h10) begin
            bad++;
            $display("FAIL coincident k=%0d an=%h seg=%h want %h 10",
                     k, an, seg, an_tab[d]);
         end
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL coincident_pend upd went 1 want always 0");
      end
   endtask

   task automatic test_bcd();
      int d;
      logic [3:0] ea;
      logic [6:0] es;
      do_reset();
      hex_mode = 1'b0;
      load_vec(16'h00A0, 4'h0, 4'hF, 4'h0);
      while (k < 40) begin
         step();
         if (k == 28) hex_mode = 1'b1;
         d = ((k - 1) / 4) % 4;
         if ((k >= 17 && k <= 24) || (k >= 33 && k <= 40)) begin
            if (d == 0) begin
               ea = 4'hE; es = 7'h40;
            end else if (k <= 24) begin
               ea = 4'hF; es = 7'h7F;
            end else begin
               ea = 4'hD; es = 7'h08;
            end
            total++;
            if (an !== ea || seg !== es) begin
               bad++;
               $display("FAIL bcd k=%0d an=%h seg=%h want %h %h",
                        k, an, seg, ea, es);
            end
         end
      end
   endtask

   task automatic test_blink();
      logic vis;
      do_reset();
      load_vec(16'h3210, 4'h0, 4'hF, 4'b0001);
      for (int f = 1; f <= 6; f++) begin
         while (k < 16 * f + 2) step();
         vis = (f == 1 || f == 4 || f == 5);
         total++;
         if (an !== (vis ? 4'hE : 4'hF) || seg !== (vis ? 7'h40 : 7'h7F)) begin
            bad++;
            $display("FAIL blink_d0 frame=%0d an=%h seg=%h want %h %h",
                     f, an, seg, vis ? 4'hE : 4'hF, vis ? 7'h40 : 7'h7F);
         end
         while (k < 16 * f + 6) step();
         total++;
         if (an !== 4'hD || seg !== 7'h79) begin
            bad++;
            $display("FAIL blink_d1 frame=%0d an=%h seg=%h want D 79",
                     f, an, seg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_shadow();
      test_coincident();
      test_bcd();
      test_blink();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
